// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard receiver: folds E0/F0/E1 prefixes into one ps2_key event per make/break.
// Latency: about 2 sync + FILTER_LEN + 2 clk_sys cycles from the final ps2_clk fall to the ps2_key update.
// Backpressure: none; events are held in ps2_key and announced by a toggle of ps2_key[10].
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 48000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_dat_in,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FC_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);

    logic          clk_meta, clk_sync, dat_meta, dat_sync;
    logic          filt_clk, strobe;
    logic [FW-1:0] filt_cnt;

    logic [10:0]   sr, sr_n, shifted;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [TW-1:0] to_cnt, to_n;
    logic          ext, ext_n, rel, rel_n;
    logic [2:0]    skip, skip_n;
    logic [10:0]   key_n;
    logic          err_n;
    logic [7:0]    rx_byte;
    logic          frame_ok, status_byte;

    // Input synchronisers and clock deglitch filter; strobe marks a filtered falling edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            strobe   <= 1'b0;
        end else begin
            clk_meta <= ps2_clk_in;
            clk_sync <= clk_meta;
            dat_meta <= ps2_dat_in;
            dat_sync <= dat_meta;
            strobe   <= 1'b0;
            if (clk_sync == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FC_MAX) begin
                filt_clk <= clk_sync;
                filt_cnt <= '0;
                strobe   <= filt_clk;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign shifted = {dat_sync, sr[10:1]};
    assign rx_byte = shifted[8:1];
    assign frame_ok = !shifted[0] && shifted[10] && (^shifted[9:1]);

    always_comb begin
        status_byte = 1'b0;
        case (rx_byte)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: status_byte = 1'b1;
            default: status_byte = 1'b0;
        endcase
    end

    always_comb begin
        sr_n      = sr;
        bit_cnt_n = bit_cnt;
        to_n      = to_cnt;
        ext_n     = ext;
        rel_n     = rel;
        skip_n    = skip;
        key_n     = ps2_key;
        err_n     = 1'b0;
        if (strobe) begin
            sr_n = shifted;
            to_n = '0;
            if (bit_cnt == 4'd10) begin
                bit_cnt_n = '0;
                if (!frame_ok) begin
                    err_n  = 1'b1;
                    ext_n  = 1'b0;
                    rel_n  = 1'b0;
                    skip_n = '0;
                end else if (skip != '0) begin
                    skip_n = skip - 3'd1;
                end else if (rx_byte == 8'hE1) begin
                    // Pause sends E1 followed by seven bytes that carry no key meaning
                    skip_n = 3'd7;
                end else if (rx_byte == 8'hE0) begin
                    ext_n = 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    rel_n = 1'b1;
                end else if (!(status_byte && !ext && !rel)) begin
                    key_n = {~ps2_key[10], ~rel, ext, rx_byte};
                    ext_n = 1'b0;
                    rel_n = 1'b0;
                end
            end else begin
                bit_cnt_n = bit_cnt + 4'd1;
            end
        end else if (bit_cnt == '0) begin
            to_n = '0;
        end else if (to_cnt == TO_MAX) begin
            bit_cnt_n = '0;
            to_n      = '0;
            err_n     = 1'b1;
            ext_n     = 1'b0;
            rel_n     = 1'b0;
        end else begin
            to_n = to_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sr        <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            ext       <= 1'b0;
            rel       <= 1'b0;
            skip      <= '0;
            ps2_key   <= '0;
            frame_err <= 1'b0;
        end else begin
            sr        <= sr_n;
            bit_cnt   <= bit_cnt_n;
            to_cnt    <= to_n;
            ext       <= ext_n;
            rel       <= rel_n;
            skip      <= skip_n;
            ps2_key   <= key_n;
            frame_err <= err_n;
        end
    end

    assign busy = (bit_cnt != '0);

endmodule
